mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/cachepkg.sv | 27 ++
 rtl/mem_req_fifo.sv | 51 +++++
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cachepkg.sv
// Shared types for the cache next-level memory stage.
// Request bundle and service-FSM state encoding.
package cachepkg;

   localparam int MAX_ADDRBITS = 64;
   localparam int MAX_LINEBITS = 4096;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } memstate_t;

   // Fields are sized for the widest supported configuration;
   // narrower instances zero-fill and ignore the upper bits.
   typedef struct packed {
      logic                    write;
      logic [MAX_ADDRBITS-1:0] addr;
      logic [MAX_LINEBITS-1:0] data;
   } mem_req_t;

   // Number of byte-offset bits inside one line.
   function automatic int line_index_lsb(int items, int wordbits);
      return $clog2((items * wordbits) / 8);
   endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Two-entry in-order request queue for mem_stage.
// Push and pop on the same edge both take effect.
module mem_req_fifo
   import cachepkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     push,
   input  logic     pop,
   input  mem_req_t din,
   output logic     full,
   output logic     empty,
   output mem_req_t head
);

   mem_req_t   slot [2];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] count;
   logic       do_push;
   logic       do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = slot[rd_ptr];

   // Pointers and occupancy; cleared by reset so queued work is dropped.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry payload; validity is tracked by count, so no reset needed.
   always_ff @(posedge clock) begin
      if (do_push) slot[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_stage.sv
// Line-granular backing memory behind a cache nextlevel port.
// Fixed-latency, in-order service of queued fills and writebacks.
module mem_stage
   import cachepkg::*;
#(
   parameter int ADDRBITS  = 32,
   parameter int WORDBITS  = 32,
   parameter int LINEITEMS = 16,
   parameter int DEPTH     = 1024,
   parameter int LATENCY   = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          request,
   input  logic                          write,
   input  logic [ADDRBITS-1:0]           addr,
   input  logic [LINEITEMS*WORDBITS-1:0] wdata,
   output logic                          ready,
   output logic                          valid,
   output logic [LINEITEMS*WORDBITS-1:0] rdata,
   output logic                          busy
);

   localparam int LINEBITS = LINEITEMS * WORDBITS;
   localparam int OFFBITS  = line_index_lsb(LINEITEMS, WORDBITS);
   localparam int IDXBITS  = $clog2(DEPTH);
   localparam int CNTBITS  = (LATENCY > 2) ? $clog2(LATENCY) : 1;
   localparam logic [CNTBITS-1:0] RELOAD = CNTBITS'(LATENCY - 2);

   memstate_t            state;
   memstate_t            state_n;
   logic [CNTBITS-1:0]   cnt;
   logic [CNTBITS-1:0]   cnt_n;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic                 enter_respond;
   mem_req_t             in_req;
   mem_req_t             head;
   logic                 cur_write;
   logic [IDXBITS-1:0]   cur_idx;
   logic [LINEBITS-1:0]  cur_data;
   logic [LINEBITS-1:0]  store [DEPTH];
   logic                 unused_head;

   // Pack the incoming request into the shared bundle.
   always_comb begin
      in_req                    = '0;
      in_req.write              = write;
      in_req.addr[ADDRBITS-1:0] = addr;
      in_req.data[LINEBITS-1:0] = wdata;
   end

   mem_req_fifo u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (request),
      .pop   (pop),
      .din   (in_req),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // Offset bits, aliased high bits and padding are not needed.
   assign unused_head = ^{head.addr, head.data};

   assign ready = ~full;
   assign valid = (state == RESPOND);
   assign busy  = (state != IDLE) | ~empty;

   assign enter_respond = (state == ACCESS) && (cnt == '0);

   // Service sequencing: pop on entry to ACCESS, count down, respond once.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_n = ACCESS;
               cnt_n   = RELOAD;
            end
         end
         ACCESS: begin
            if (cnt == '0) state_n = RESPOND;
            else           cnt_n   = cnt - CNTBITS'(1);
         end
         RESPOND: begin
            if (!empty) begin
               pop     = 1'b1;
               state_n = ACCESS;
               cnt_n   = RELOAD;
            end else begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // FSM state and latency counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Capture the request taken from the queue head for the whole service.
   always_ff @(posedge clock) begin
      if (pop) begin
         cur_write <= head.write;
         cur_idx   <= head.addr[OFFBITS +: IDXBITS];
         cur_data  <= head.data[LINEBITS-1:0];
      end
   end

   // Storage commit happens only on RESPOND entry, so reset drops writes.
   always_ff @(posedge clock) begin
      if (enter_respond && cur_write) store[cur_idx] <= cur_data;
   end

   // Read data register; held across write responses.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (enter_respond && !cur_write) begin
         rdata <= store[cur_idx];
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus
// randomized traffic against a timing/storage reference model.
module tb_mem_stage;

   localparam int LAT = 4;
   localparam int LB  = 512;

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic          request = 1'b0;
   logic          write   = 1'b0;
   logic [31:0]   addr    = '0;
   logic [LB-1:0] wdata   = '0;
   logic          ready;
   logic          valid;
   logic          busy;
   logic [LB-1:0] rdata;

   mem_stage #(
      .ADDRBITS  (32),
      .WORDBITS  (32),
      .LINEITEMS (16),
      .DEPTH     (1024),
      .LATENCY   (LAT)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .request (request),
      .write   (write),
      .addr    (addr),
      .wdata   (wdata),
      .ready   (ready),
      .valid   (valid),
      .rdata   (rdata),
      .busy    (busy)
   );

   always #5 clock = ~clock;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [LB-1:0] act,
                      input logic [LB-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: no event within bound", nm);
   endtask

   // Reference model: each accepted request gets a service start edge
   // start = max(accept+1, previous start + LAT); it responds on edge
   // start+LAT-1 and occupies the stage until edge start+LAT.
   typedef struct {
      bit            w;
      int            idx;
      logic [LB-1:0] d;
      int            start;
   } item_t;

   item_t         q[$];
   logic [LB-1:0] mem[int];
   int            cyc        = 0;
   int            last_start = -1000;
   int            me, ms, mw;
   bit            m_ready    = 1'b1;
   bit            m_busy     = 1'b0;
   bit            m_valid    = 1'b0;
   bit            m_acc      = 1'b0;
   bit            m_rknown   = 1'b1;
   logic [LB-1:0] m_rdata    = '0;
   bit            chk_en     = 1'b0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         q.delete();
         last_start = -1000;
         m_ready    = 1'b1;
         m_busy     = 1'b0;
         m_valid    = 1'b0;
         m_acc      = 1'b0;
         m_rdata    = '0;
         m_rknown   = 1'b1;
      end else begin
         cyc++;
         me    = cyc;
         m_acc = 1'b0;
         if (request && m_ready) begin
            ms = (me + 1 > last_start + LAT) ? me + 1 : last_start + LAT;
            last_start = ms;
            q.push_back('{write, int'((addr >> 6) & 32'd1023), wdata, ms});
            m_acc = 1'b1;
         end
         m_valid = 1'b0;
         foreach (q[i]) begin
            if (q[i].start + LAT - 1 == me) begin
               m_valid = 1'b1;
               if (q[i].w) begin
                  mem[q[i].idx] = q[i].d;
               end else if (mem.exists(q[i].idx)) begin
                  m_rdata  = mem[q[i].idx];
                  m_rknown = 1'b1;
               end else begin
                  m_rknown = 1'b0;
               end
            end
         end
         while (q.size() > 0 && q[0].start + LAT <= me) void'(q.pop_front());
         mw = 0;
         foreach (q[i]) if (q[i].start > me) mw++;
         m_ready = (mw < 2);
         m_busy  = (q.size() != 0);
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("valid", LB'(valid), LB'(m_valid));
         chk("ready", LB'(ready), LB'(m_ready));
         chk("busy",  LB'(busy),  LB'(m_busy));
         if (m_rknown) chk("rdata", rdata, m_rdata);
      end
   end

   function automatic logic [LB-1:0] rand_line();
      logic [LB-1:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic issue(input bit w, input logic [31:0] a,
                        input logic [LB-1:0] d, output int acc);
      request = 1'b1;
      write   = w;
      addr    = a;
      wdata   = d;
      acc     = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (m_acc) begin
            acc = cyc;
            break;
         end
      end
      if (acc < 0) timeout("accept");
   endtask

   task automatic wait_valid(output int e);
      e = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (valid === 1'b1) begin
            e = cyc;
            break;
         end
      end
      if (e < 0) timeout("valid");
   endtask

   logic [LB-1:0] pa5, p3c, pff, d1;
   int            a, a1, e, e1, e2, e3;
   int            lines[8];
   logic [31:0]   ra;

   initial begin
      pa5 = {64{8'hA5}};
      p3c = {64{8'h3C}};
      pff = {64{8'hFF}};
      d1  = {16{32'h1234_5678}};

      #1 reset = 1'b0;
      #1 chk_en = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", LB'(ready), LB'(1));
      chk("rst_busy",  LB'(busy),  LB'(0));
      chk("rst_valid", LB'(valid), LB'(0));
      chk("rst_rdata", rdata, '0);
      reset = 1'b1;

      // Write at edge 10 -> response after edge 14, rdata untouched.
      do begin
         @(posedge clock);
         #1;
      end while (cyc < 9);
      issue(1'b1, 32'h0000_0040, pa5, a);
      request = 1'b0;
      chk("wr_accept_edge", LB'(a), LB'(10));
      wait_valid(e);
      chk("wr_valid_edge", LB'(e), LB'(14));
      chk("wr_rdata_hold", rdata, '0);

      // Plain read and an aliased read of the same line.
      issue(1'b0, 32'h0000_0040, '0, a);
      request = 1'b0;
      wait_valid(e);
      chk("rd_latency", LB'(e - a), LB'(4));
      chk("rd_data", rdata, pa5);
      issue(1'b0, 32'h0001_0040, '0, a);
      request = 1'b0;
      wait_valid(e);
      chk("alias_latency", LB'(e - a), LB'(4));
      chk("alias_data", rdata, pa5);

      // Three back-to-back: write, read same line, read other line.
      issue(1'b1, 32'h0000_0100, d1, a1);
      issue(1'b0, 32'h0000_0100, '0, a);
      issue(1'b0, 32'h0000_0040, '0, a);
      chk("queue_full_ready", LB'(ready), LB'(0));
      request = 1'b0;
      wait_valid(e1);
      wait_valid(e2);
      chk("raw_data", rdata, d1);
      wait_valid(e3);
      chk("b2b_first", LB'(e1 - a1), LB'(4));
      chk("b2b_second", LB'(e2 - a1), LB'(8));
      chk("b2b_third", LB'(e3 - a1), LB'(12));
      chk("b2b_third_data", rdata, pa5);

      // Reset during ACCESS of a write must not modify storage.
      issue(1'b1, 32'h0000_0080, p3c, a);
      request = 1'b0;
      wait_valid(e);
      issue(1'b1, 32'h0000_0080, pff, a);
      request = 1'b0;
      repeat (2) begin
         @(posedge clock);
         #1;
      end
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", LB'(ready), LB'(1));
      chk("mid_rst_busy",  LB'(busy),  LB'(0));
      chk("mid_rst_valid", LB'(valid), LB'(0));
      @(posedge clock);
      #1 reset = 1'b1;
      issue(1'b0, 32'h0000_0080, '0, a);
      request = 1'b0;
      wait_valid(e);
      chk("post_rst_latency", LB'(e - a), LB'(4));
      chk("post_rst_data", rdata, p3c);

      // Idle with request low.
      repeat (20) begin
         @(negedge clock);
         chk("idle_valid", LB'(valid), LB'(0));
         chk("idle_busy",  LB'(busy),  LB'(0));
         chk("idle_ready", LB'(ready), LB'(1));
      end

      // Random traffic over a small set of lines with aliasing.
      foreach (lines[i]) begin
         lines[i] = $urandom_range(0, 1023);
         issue(1'b1, 32'(lines[i]) << 6, rand_line(), a);
      end
      for (int n = 0; n < 300; n++) begin
         int gap;
         gap = $urandom_range(0, 3);
         if (gap > 0) begin
            request = 1'b0;
            repeat (gap) begin
               @(posedge clock);
               #1;
            end
         end
         ra = ($urandom & 32'hFFFF_0000)
            | (32'(lines[$urandom_range(0, 7)]) << 6)
            | 32'($urandom_range(0, 63));
         issue(1'($urandom_range(0, 1)), ra, rand_line(), a);
      end
      request = 1'b0;
      for (int i = 0; i < 200 && m_busy; i++) begin
         @(posedge clock);
         #1;
      end
      if (m_busy) timeout("drain");
      repeat (3) @(posedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
